// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: datapath width, reset PC and the pipeline bubble
// instruction used by fetch, decode and the hazard unit.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [31:0] PC_STEP   = 32'h0000_0004;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address out, combinational word back.
interface fetch_stage_if #(
    parameter int XLEN = riscv_pkg::XLEN
);

    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);

endinterface

// File: rtl/pipe_reg_enc.sv
// Pipeline flop with async reset, synchronous clear and load enable.
// Clear outranks enable so a flush always wins over a stall.
module pipe_reg_enc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] CLEAR_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // State update: reset, then clear, then enabled load, else hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (clr) begin
            q <= CLEAR_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register of the 5-stage RV32I core: PC register, next-PC
// selection (sequential or E-stage redirect) and the decode-side latch.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(riscv_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallf,
    input  logic                stalld,
    input  logic                flushd,
    input  logic                pcsrce,
    input  logic                pcjalsrce,
    input  logic [XLEN-1:0]     pctargete,
    input  logic [XLEN-1:0]     aluresulte,
    fetch_stage_if.master       imem,
    output logic [XLEN-1:0]     pcf,
    output logic [31:0]         instrd,
    output logic [XLEN-1:0]     pcd,
    output logic [XLEN-1:0]     pcplus4d,
    output logic                validd
);

    localparam int               IFID_W      = 1 + 32 + 2 * XLEN;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {1'b0, NOP_INSTR, {XLEN{1'b0}}, {XLEN{1'b0}}};

    logic [XLEN-1:0]   pcplus4f;
    logic [XLEN-1:0]   jtarget;
    logic [XLEN-1:0]   pcnextf;
    logic              pc_en;
    logic              ifid_en;
    logic [IFID_W-1:0] ifid_d;
    logic [IFID_W-1:0] ifid_q;

    // Wraps silently at the top of the address space; JALR drops bit 0 only,
    // so a misaligned bit 1 reaches the PC untouched.
    assign pcplus4f = pcf + XLEN'(PC_STEP);
    assign jtarget  = pcjalsrce ? {aluresulte[XLEN-1:1], 1'b0} : pctargete;
    assign pcnextf  = pcsrce ? jtarget : pcplus4f;

    // A redirect must land even while the hazard unit is stalling fetch.
    assign pc_en   = ~stallf | pcsrce;
    assign ifid_en = ~stalld;
    assign ifid_d  = {1'b1, imem.imem_rdata, pcf, pcplus4f};

    assign imem.imem_addr = pcf;

    pipe_reg_enc #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC),
        .CLEAR_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (reset),
        .en  (pc_en),
        .clr (1'b0),
        .d   (pcnextf),
        .q   (pcf)
    );

    pipe_reg_enc #(
        .WIDTH     (IFID_W),
        .RESET_VAL (IFID_BUBBLE),
        .CLEAR_VAL (IFID_BUBBLE)
    ) u_ifid_reg (
        .clk (clk),
        .rst (reset),
        .en  (ifid_en),
        .clr (flushd),
        .d   (ifid_d),
        .q   (ifid_q)
    );

    assign {validd, instrd, pcd, pcplus4d} = ifid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, random stimulus
// against a behavioural model, and a wrap-around instance with RESET_PC at the top.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset, rst_b;
    logic        stallf, stalld, flushd, pcsrce, pcjalsrce;
    logic [31:0] pctargete, aluresulte;
    logic [31:0] pcf, instrd, pcd, pcplus4d;
    logic        validd;

    logic        b_stallf, b_stalld, b_flushd, b_pcsrce, b_pcjalsrce;
    logic [31:0] b_pctargete, b_aluresulte;
    logic [31:0] pcf_b, instrd_b, pcd_b, pcplus4d_b;
    logic        validd_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Instruction memory contents: fixed word at 0, address-derived elsewhere.
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        else                    return a ^ 32'h5A5A_0013;
    endfunction

    fetch_stage_if #(.XLEN(32)) bus_a ();
    fetch_stage_if #(.XLEN(32)) bus_b ();
    assign bus_a.imem_rdata = mem(bus_a.imem_addr);
    assign bus_b.imem_rdata = mem(bus_b.imem_addr);

    fetch_stage dut (
        .clk(clk), .reset(reset), .stallf(stallf), .stalld(stalld), .flushd(flushd),
        .pcsrce(pcsrce), .pcjalsrce(pcjalsrce), .pctargete(pctargete), .aluresulte(aluresulte),
        .imem(bus_a.master), .pcf(pcf), .instrd(instrd), .pcd(pcd), .pcplus4d(pcplus4d),
        .validd(validd)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(rst_b), .stallf(b_stallf), .stalld(b_stalld), .flushd(b_flushd),
        .pcsrce(b_pcsrce), .pcjalsrce(b_pcjalsrce), .pctargete(b_pctargete),
        .aluresulte(b_aluresulte), .imem(bus_b.master), .pcf(pcf_b), .instrd(instrd_b),
        .pcd(pcd_b), .pcplus4d(pcplus4d_b), .validd(validd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_instr,
                         input logic [31:0] e_pcd, input logic [31:0] e_p4, input logic e_v);
        chk({tag, ".pcf"},       pcf,             e_pcf);
        chk({tag, ".imem_addr"}, bus_a.imem_addr, e_pcf);
        chk({tag, ".instrd"},    instrd,          e_instr);
        chk({tag, ".pcd"},       pcd,             e_pcd);
        chk({tag, ".pcplus4d"},  pcplus4d,        e_p4);
        chk({tag, ".validd"},    {31'b0, validd}, {31'b0, e_v});
    endtask

    typedef struct {
        logic        sf, sd, fd, ps, pj;
        logic [31:0] pt, alu;
        logic [31:0] e_pcf, e_pcd;
        logic        e_v;
    } vec_t;

    function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic ps,
                                input logic pj, input logic [31:0] pt, input logic [31:0] alu,
                                input logic [31:0] e_pcf, input logic [31:0] e_pcd, input logic e_v);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.ps = ps; v.pj = pj;
        v.pt = pt; v.alu = alu; v.e_pcf = e_pcf; v.e_pcd = e_pcd; v.e_v = e_v;
        return v;
    endfunction

    task automatic drive(input logic sf, input logic sd, input logic fd, input logic ps,
                         input logic pj, input logic [31:0] pt, input logic [31:0] alu);
        stallf = sf; stalld = sd; flushd = fd; pcsrce = ps; pcjalsrce = pj;
        pctargete = pt; aluresulte = alu;
    endtask

    vec_t vt[15];

    logic [31:0] m_pc, m_instr, m_pcd, m_p4, m_next;
    logic        m_v;
    logic        r_sf, r_sd, r_fd, r_ps, r_pj;
    logic [31:0] r_pt, r_alu;

    initial begin
        // Sequence through reset, stall, branch, JALR, combined redirect+stall, bit1 target.
        vt[0]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_0004, 32'h0000_0000, 1);
        vt[1]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_0008, 32'h0000_0004, 1);
        vt[2]  = mk(1,1,0,0,0, 32'h0,     32'h0,     32'h0000_0008, 32'h0000_0004, 1);
        vt[3]  = mk(1,1,0,0,0, 32'h0,     32'h0,     32'h0000_0008, 32'h0000_0004, 1);
        vt[4]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_000C, 32'h0000_0008, 1);
        vt[5]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_0010, 32'h0000_000C, 1);
        vt[6]  = mk(0,0,1,1,0, 32'h40,    32'h0,     32'h0000_0040, 32'h0000_0000, 0);
        vt[7]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_0044, 32'h0000_0040, 1);
        vt[8]  = mk(0,0,1,1,1, 32'h1234,  32'h81,    32'h0000_0080, 32'h0000_0000, 0);
        vt[9]  = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_0084, 32'h0000_0080, 1);
        vt[10] = mk(1,1,1,1,0, 32'h202,   32'h0,     32'h0000_0202, 32'h0000_0000, 0);
        vt[11] = mk(0,1,0,0,0, 32'h0,     32'h0,     32'h0000_0206, 32'h0000_0000, 0);
        vt[12] = mk(0,0,0,0,0, 32'h0,     32'h0,     32'h0000_020A, 32'h0000_0206, 1);
        vt[13] = mk(0,0,0,0,1, 32'h0,     32'h999,   32'h0000_020E, 32'h0000_020A, 1);
        vt[14] = mk(1,0,0,0,0, 32'h0,     32'h0,     32'h0000_020E, 32'h0000_020E, 1);

        drive(0,0,0,0,0, 32'h0, 32'h0);
        b_stallf = 1'b0; b_stalld = 1'b0; b_flushd = 1'b0; b_pcsrce = 1'b0; b_pcjalsrce = 1'b0;
        b_pctargete = 32'h0; b_aluresulte = 32'h0;
        reset = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_a("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);

        // Reset arriving mid-cycle must clear everything without waiting for an edge.
        #3;
        reset = 1'b1;
        #1;
        chk_a("midreset", 32'h0, NOP, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].sf, vt[i].sd, vt[i].fd, vt[i].ps, vt[i].pj, vt[i].pt, vt[i].alu);
            @(posedge clk);
            #1;
            chk_a($sformatf("vec%0d", i), vt[i].e_pcf,
                  vt[i].e_v ? mem(vt[i].e_pcd) : NOP, vt[i].e_pcd,
                  vt[i].e_v ? vt[i].e_pcd + 32'd4 : 32'h0, vt[i].e_v);
        end

        // Random phase from a fresh reset against the behavioural model.
        reset = 1'b1;
        #1;
        drive(0,0,0,0,0, 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        m_pc = 32'h0; m_instr = NOP; m_pcd = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            r_sf  = ($urandom_range(0, 3) == 0);
            r_sd  = ($urandom_range(0, 3) == 0);
            r_ps  = ($urandom_range(0, 4) == 0);
            r_fd  = r_ps ? 1'b1 : ($urandom_range(0, 9) == 0);
            r_pj  = $urandom_range(0, 1) == 1;
            r_pt  = $urandom;
            r_alu = $urandom;
            drive(r_sf, r_sd, r_fd, r_ps, r_pj, r_pt, r_alu);
            if (r_ps)      m_next = r_pj ? (r_alu & 32'hFFFF_FFFE) : r_pt;
            else if (r_sf) m_next = m_pc;
            else           m_next = m_pc + 32'd4;
            if (r_fd) begin
                m_instr = NOP; m_pcd = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
            end else if (!r_sd) begin
                m_instr = mem(m_pc); m_pcd = m_pc; m_p4 = m_pc + 32'd4; m_v = 1'b1;
            end
            m_pc = m_next;
            @(posedge clk);
            #1;
            chk_a($sformatf("rand%0d", i), m_pc, m_instr, m_pcd, m_p4, m_v);
        end

        // Wrap-around instance: first fetch from 0xFFFF_FFFC, PC+4 wraps to 0.
        chk("wrap.reset_pcf", pcf_b, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        chk("wrap.pcf",      pcf_b,               32'h0000_0000);
        chk("wrap.instrd",   instrd_b,            mem(32'hFFFF_FFFC));
        chk("wrap.pcd",      pcd_b,               32'hFFFF_FFFC);
        chk("wrap.pcplus4d", pcplus4d_b,          32'h0000_0000);
        chk("wrap.validd",   {31'b0, validd_b},   32'h1);
        @(posedge clk);
        #1;
        chk("wrap.pcf2",     pcf_b,               32'h0000_0004);
        chk("wrap.pcd2",     pcd_b,               32'h0000_0000);
        chk("wrap.instrd2",  instrd_b,            32'h0050_0093);
        #2;
        rst_b = 1'b1;
        #1;
        chk("wrap.async_pcf",    pcf_b,             32'hFFFF_FFFC);
        chk("wrap.async_instrd", instrd_b,          NOP);
        chk("wrap.async_pcd",    pcd_b,             32'h0);
        chk("wrap.async_p4",     pcplus4d_b,        32'h0);
        chk("wrap.async_validd", {31'b0, validd_b}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
